// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the buffered UART transmitter: TX FSM encodings,
// control register bit positions and the default bit period.
package uart_tx_queue_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t IDLE  = 2'b00;
  localparam tx_state_t START = 2'b01;
  localparam tx_state_t DATA  = 2'b10;
  localparam tx_state_t STOP  = 2'b11;

  localparam int unsigned CTRL_RX_EN = 0;
  localparam int unsigned CTRL_TX_EN = 1;

  // 25 MHz system clock -> 115200 baud
  localparam int unsigned DEFAULT_CPB = 217;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Register-side and line-side signals of the buffered UART transmitter.
// master = CPU/control side, slave = the transmitter.
interface uart_tx_queue_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CPB_WIDTH  = 32
);

  logic                 en;
  logic                 stop2;
  logic                 wr;
  logic [7:0]           din;
  logic [CPB_WIDTH-1:0] cycles_per_bit;
  logic                 clr_ovr;
  logic                 TxD;
  logic                 full;
  logic                 empty;
  logic [ADDR_WIDTH:0]  level;
  logic                 busy;
  logic                 tc;
  logic                 ovr;

  modport master (
    output en, stop2, wr, din, cycles_per_bit, clr_ovr,
    input  TxD, full, empty, level, busy, tc, ovr
  );

  modport slave (
    input  en, stop2, wr, din, cycles_per_bit, clr_ovr,
    output TxD, full, empty, level, busy, tc, ovr
  );

endinterface

// File: rtl/uart_tx_queue_fifo.sv
// Pointer-only FIFO storage; occupancy and full/empty are tracked by the owner,
// which must never push when full or pop when empty.
module uart_tx_queue_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered UART transmitter: queues CPU bytes and sends them as back-to-back
// 8N1/8N2 frames. Owns occupancy, overrun flag and the serialiser FSM.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CPB_WIDTH  = 32
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_queue_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH:0]  level_q, level_d;
  logic                 ovr_q, ovr_d;
  tx_state_t            state_q, state_d;
  logic [CPB_WIDTH-1:0] cnt_q, cnt_d;
  logic [CPB_WIDTH-1:0] cpb_q, cpb_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 stop2_q, stop2_d;

  logic                 full, empty, push, pop, load, bit_end;
  logic [7:0]           fifo_rdata;
  logic [CPB_WIDTH-1:0] cpb_clamped;

  assign full        = (level_q == (ADDR_WIDTH + 1)'(Depth));
  assign empty       = (level_q == '0);
  assign push        = bus.wr & ~full;
  assign pop         = load;
  assign bit_end     = (cnt_q == cpb_q - CPB_WIDTH'(1));
  assign cpb_clamped = (bus.cycles_per_bit < CPB_WIDTH'(2)) ? CPB_WIDTH'(2) : bus.cycles_per_bit;

  uart_tx_queue_fifo #(
    .WIDTH      (8),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.din),
    .rdata_o (fifo_rdata)
  );

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   level_d = level_q - (ADDR_WIDTH + 1)'(1);
      default: level_d = level_q;
    endcase
    // A dropped write beats a simultaneous clear.
    ovr_d = ovr_q;
    if (bus.wr && full)   ovr_d = 1'b1;
    else if (bus.clr_ovr) ovr_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpb_d   = cpb_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    stop2_d = stop2_q;
    load    = 1'b0;
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CPB_WIDTH'(1);
    case (state_q)
      IDLE:  load = bus.en & ~empty;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;  // wraps to 0 on the last bit, reused as stop counter
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !bit_q[0]) begin
            bit_d = 3'd1;
          end else begin
            load = bus.en & ~empty;
            if (!load) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shift_d = fifo_rdata;
      cpb_d   = cpb_clamped;
      stop2_d = bus.stop2;
      cnt_d   = '0;
      bit_d   = '0;
      state_d = START;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      ovr_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      cpb_q   <= CPB_WIDTH'(DEFAULT_CPB);
      bit_q   <= '0;
      shift_q <= '0;
      stop2_q <= 1'b0;
    end else begin
      level_q <= level_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpb_q   <= cpb_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stop2_q <= stop2_d;
    end
  end

  assign bus.TxD   = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
  assign bus.busy  = (state_q != IDLE);
  assign bus.tc    = empty & (state_q == IDLE);
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.level = level_q;
  assign bus.ovr   = ovr_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed frame/FIFO scenarios plus random traffic, all
// checked every cycle against a frame-timing model built from queue arithmetic.
module tb_uart_tx_queue;

  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 32;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic reset;

  uart_tx_queue_if #(.ADDR_WIDTH(AW), .CPB_WIDTH(CW)) bus ();

  uart_tx_queue #(.ADDR_WIDTH(AW), .CPB_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: byte queue plus elapsed time inside the current frame.
  logic [7:0]  m_q[$];
  bit          m_busy = 1'b0;
  int unsigned m_t    = 0;
  int unsigned m_len  = 20;
  int unsigned m_cpb  = 2;
  logic [7:0]  m_cur  = '0;
  bit          m_ovr  = 1'b0;

  logic cap [128];
  logic tcv [128];

  function automatic logic m_txd();
    int unsigned idx;
    if (!m_busy) return 1'b1;
    idx = m_t / m_cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] pack(input logic txd, input logic busy, input logic full,
                                       input logic empty, input logic tc, input logic ovr,
                                       input logic [4:0] lvl);
    return {21'd0, txd, busy, full, empty, tc, ovr, lvl};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(bus.TxD, bus.busy, bus.full, bus.empty, bus.tc, bus.ovr, bus.level);
  endfunction

  function automatic logic [31:0] model_vec();
    int sz = m_q.size();
    return pack(m_txd(), m_busy, sz == Depth, sz == 0, (sz == 0) && !m_busy, m_ovr, 5'(sz));
  endfunction

  function automatic logic [9:0] decode(input int cpb);
    logic [9:0] v;
    for (int k = 0; k < 10; k++) v[k] = cap[k * cpb + cpb / 2];
    return v;
  endfunction

  task automatic model_edge();
    bit pre_full  = (m_q.size() == Depth);
    bit pre_empty = (m_q.size() == 0);
    bit ending    = 1'b0;
    bit do_pop    = 1'b0;
    if (reset) begin
      m_q.delete();
      m_busy = 1'b0;
      m_t    = 0;
      m_ovr  = 1'b0;
      return;
    end
    if (!m_busy) do_pop = bus.en && !pre_empty;
    else if (m_t == m_len - 1) begin
      ending = 1'b1;
      do_pop = bus.en && !pre_empty;
    end
    if (do_pop) begin
      m_cur  = m_q.pop_front();
      m_cpb  = (bus.cycles_per_bit < 2) ? 2 : bus.cycles_per_bit;
      m_len  = (bus.stop2 ? 11 : 10) * m_cpb;
      m_t    = 0;
      m_busy = 1'b1;
    end else if (ending) begin
      m_busy = 1'b0;
      m_t    = 0;
    end else if (m_busy) begin
      m_t++;
    end
    if (bus.wr && pre_full) m_ovr = 1'b1;
    else if (bus.clr_ovr)   m_ovr = 1'b0;
    if (bus.wr && !pre_full) m_q.push_back(bus.din);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("cycle", dut_vec(), model_vec());
  endtask

  task automatic wait_fall(output bit ok);
    int n = 0;
    while (bus.TxD !== 1'b0 && n < 3000) begin
      step();
      n++;
    end
    ok = (bus.TxD === 1'b0);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_fall: TxD=%b after %0d cycles, required 0", bus.TxD, n);
    end
  endtask

  task automatic rx_frame(input int cpb, output logic [7:0] b, output int fall, output int lv);
    bit ok;
    b = 'x;
    fall = -1;
    lv = -1;
    wait_fall(ok);
    if (!ok) return;
    fall = cyc;
    lv   = int'(bus.level);
    repeat (cpb / 2) step();
    chk("rx_start", bus.TxD, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (cpb) step();
      b[k] = bus.TxD;
    end
    repeat (cpb) step();
    chk("rx_stop", bus.TxD, 1'b1);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       clr;
    logic [4:0] lvl;
    logic       full;
    logic       ovr;
  } vec_t;

  vec_t tab [20];

  initial begin
    logic [7:0] b;
    int fall, prev, lv, first, cnt;
    bit ok;

    for (int i = 0; i < 16; i++) tab[i] = '{1'b1, 8'(8'h10 + i), 1'b0, 5'(i + 1), (i == 15), 1'b0};
    tab[16] = '{1'b1, 8'hEE, 1'b0, 5'd16, 1'b1, 1'b1};
    tab[17] = '{1'b1, 8'hEF, 1'b1, 5'd16, 1'b1, 1'b1};
    tab[18] = '{1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0};
    tab[19] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b0};

    reset = 1'b1;
    bus.en = 1'b0;
    bus.stop2 = 1'b0;
    bus.wr = 1'b0;
    bus.din = '0;
    bus.cycles_per_bit = 4;
    bus.clr_ovr = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("reset", dut_vec(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0));

    // Single 0x55 frame: latency and completion time.
    bus.en = 1'b1;
    bus.wr = 1'b1;
    bus.din = 8'h55;
    step();
    bus.wr = 1'b0;
    chk("t1_level", bus.level, 1);
    step();
    chk("t1_fall", bus.TxD, 1'b0);
    for (int i = 0; i < 48; i++) begin
      cap[i] = bus.TxD;
      tcv[i] = bus.tc;
      step();
    end
    chk("t1_frame", decode(4), {1'b1, 8'h55, 1'b0});
    first = -1;
    for (int i = 0; i < 48; i++) if (tcv[i] === 1'b1 && first < 0) first = i;
    chk("t1_tc", first, 40);

    // Three queued bytes go out back to back.
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wr = 1'b1;
      bus.din = 8'(8'h41 + i);
      step();
    end
    bus.wr = 1'b0;
    chk("t2_level3", bus.level, 3);
    bus.en = 1'b1;
    prev = 0;
    for (int f = 0; f < 3; f++) begin
      rx_frame(4, b, fall, lv);
      chk("t2_byte", b, 8'(8'h41 + f));
      chk("t2_level", lv, 2 - f);
      if (f > 0) chk("t2_gap", fall - prev, 40);
      prev = fall;
    end
    repeat (10) step();

    // Fill to full, overrun, clear, then drain in order.
    bus.en = 1'b0;
    foreach (tab[i]) begin
      bus.wr = tab[i].wr;
      bus.din = tab[i].din;
      bus.clr_ovr = tab[i].clr;
      step();
      chk("t3_level", bus.level, tab[i].lvl);
      chk("t3_full", bus.full, tab[i].full);
      chk("t3_ovr", bus.ovr, tab[i].ovr);
    end
    bus.wr = 1'b0;
    bus.clr_ovr = 1'b0;
    bus.en = 1'b1;
    for (int f = 0; f < 16; f++) begin
      rx_frame(4, b, fall, lv);
      chk("t3_byte", b, 8'(8'h10 + f));
    end
    repeat (10) step();

    // Two stop bits at the minimum bit period.
    bus.en = 1'b0;
    bus.stop2 = 1'b1;
    bus.cycles_per_bit = 2;
    bus.wr = 1'b1;
    bus.din = 8'hFF;
    step();
    step();
    bus.wr = 1'b0;
    bus.en = 1'b1;
    rx_frame(2, b, prev, lv);
    chk("t4_byte0", b, 8'hFF);
    rx_frame(2, b, fall, lv);
    chk("t4_byte1", b, 8'hFF);
    chk("t4_gap", fall - prev, 22);
    repeat (30) step();
    bus.stop2 = 1'b0;
    bus.cycles_per_bit = 4;

    // Reset during the data bits of a frame with more bytes queued.
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr = 1'b1;
      bus.din = (i == 0) ? 8'h00 : 8'(8'hA0 + i);
      step();
    end
    bus.wr = 1'b0;
    bus.en = 1'b1;
    wait_fall(ok);
    repeat (12) step();
    chk("t5_busy_pre", bus.busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_after", dut_vec(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0));
    cnt = 0;
    repeat (80) begin
      step();
      if (bus.TxD !== 1'b1) cnt++;
    end
    chk("t5_no_frame", cnt, 0);

    // Bit period change and enable drop mid-frame.
    bus.en = 1'b0;
    bus.cycles_per_bit = 4;
    for (int i = 0; i < 3; i++) begin
      bus.wr = 1'b1;
      bus.din = (i == 0) ? 8'h3C : (i == 1) ? 8'h5A : 8'h99;
      step();
    end
    bus.wr = 1'b0;
    bus.en = 1'b1;
    wait_fall(ok);
    for (int i = 0; i < 64; i++) begin
      cap[i] = bus.TxD;
      if (i == 6) begin
        bus.cycles_per_bit = 8;
        bus.en = 1'b0;
      end
      step();
    end
    chk("t6_frame", decode(4), {1'b1, 8'h3C, 1'b0});
    cnt = 0;
    for (int i = 40; i < 64; i++) if (cap[i] !== 1'b1) cnt++;
    chk("t6_idle", cnt, 0);
    chk("t6_level", bus.level, 2);

    // Random traffic against the model.
    bus.en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      bus.wr = ($urandom_range(0, 99) < 35);
      bus.din = 8'($urandom);
      bus.clr_ovr = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 199) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 299) == 0) bus.stop2 = ~bus.stop2;
      if ($urandom_range(0, 149) == 0) bus.cycles_per_bit = $urandom_range(0, 5);
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
